// File: rtl/if_pc_gen_pkg.sv
// Shared defaults for the fetch-stage PC generator.
// Holds the default address width, sequential step and the reset/exception vectors
// used by if_pc_gen and its incrementer.
package if_pc_gen_pkg;

  localparam int          PC_ADDR_W    = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0180;

endpackage

// File: rtl/if_pcadd_n.sv
// Purpose: PC + STEP incrementer, wraps modulo 2^ADDR_W.
// Latency: purely combinational.
// Backpressure: none; no flow control.
// Ports: addr (current PC), addr_inc (addr + STEP).
module if_pcadd_n #(
  parameter int ADDR_W = 32,
  parameter int STEP   = 4
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_inc
);

  // The carry out of the top bit is dropped, which gives the modulo wrap.
  assign addr_inc = addr + ADDR_W'(STEP);

endmodule

// File: rtl/if_pc_gen.sv
// Purpose: fetch-stage program counter with exception, redirect and stall handling.
// Latency: every PC change is visible on o_addr_pc one cycle after its cause.
// Backpressure: i_stall holds the PC; a redirect seen while stalled is parked and
//   applied on the first unstalled cycle (a later redirect overwrites it).
// Ports: i_clk/i_rst (sync active-high), i_stall, i_exc, i_redirect, i_addr_target;
//   o_addr_pc (registered PC), o_addr_pcadd4 (PC + STEP), o_valid, o_misalign.
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = PC_ADDR_W,
  parameter int                STEP      = PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_exc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_addr_target,
  output logic [ADDR_W-1:0] o_addr_pc,
  output logic [ADDR_W-1:0] o_addr_pcadd4,
  output logic              o_valid,
  output logic              o_misalign
);

  // Bits below log2(STEP); all zero when STEP is 1.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] pend_addr_nxt;
  logic              pend_vld_q;
  logic              pend_vld_nxt;
  logic              valid_q;
  logic              misalign_q;
  logic [ADDR_W-1:0] target_masked;
  logic              target_misaligned;

  if_pcadd_n #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_pcadd (
    .addr     (pc_q),
    .addr_inc (pc_inc)
  );

  assign target_masked     = i_addr_target & ~LOW_MASK;
  assign target_misaligned = |(i_addr_target & LOW_MASK);

  // Priority: exception, redirect, parked redirect, stall, sequential.
  // Reset is handled in the register block and overrides all of this.
  always_comb begin
    pc_nxt        = pc_q;
    pend_addr_nxt = pend_addr_q;
    pend_vld_nxt  = pend_vld_q;
    if (i_exc) begin
      pc_nxt       = EXC_VEC;
      pend_vld_nxt = 1'b0;
    end else if (i_redirect) begin
      if (i_stall) begin
        // Park the target; a newer redirect in the same stall replaces it.
        pend_addr_nxt = target_masked;
        pend_vld_nxt  = 1'b1;
      end else begin
        pc_nxt       = target_masked;
        pend_vld_nxt = 1'b0;
      end
    end else if (pend_vld_q && !i_stall) begin
      pc_nxt       = pend_addr_q;
      pend_vld_nxt = 1'b0;
    end else if (!i_stall) begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q        <= RESET_VEC;
      pend_addr_q <= '0;
      pend_vld_q  <= 1'b0;
      valid_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_nxt;
      pend_addr_q <= pend_addr_nxt;
      pend_vld_q  <= pend_vld_nxt;
      valid_q     <= 1'b1;
      // An exception swallows a simultaneous redirect, so that target is never accepted.
      misalign_q  <= i_redirect && !i_exc && target_misaligned;
    end
  end

  assign o_addr_pc     = pc_q;
  assign o_addr_pcadd4 = pc_inc;
  assign o_valid       = valid_q;
  assign o_misalign    = misalign_q;

endmodule

// File: tb/tb_if_pc_gen.sv
module tb_if_pc_gen;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcadd;
    logic        vld;
    logic        mis;
    string       nm;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_exc = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_addr_target = '0;
  logic [31:0] o_addr_pc;
  logic [31:0] o_addr_pcadd4;
  logic        o_valid;
  logic        o_misalign;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  if_pc_gen dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stall       (i_stall),
    .i_exc         (i_exc),
    .i_redirect    (i_redirect),
    .i_addr_target (i_addr_target),
    .o_addr_pc     (o_addr_pc),
    .o_addr_pcadd4 (o_addr_pcadd4),
    .o_valid       (o_valid),
    .o_misalign    (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are registered, so sample mid-cycle and compare against the
  // oldest expectation pushed by the stimulus.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.nm, "pc",       o_addr_pc,             e.pc);
      check(e.nm, "pcadd",    o_addr_pcadd4,         e.pcadd);
      check(e.nm, "valid",    {31'b0, o_valid},      {31'b0, e.vld});
      check(e.nm, "misalign", {31'b0, o_misalign},   {31'b0, e.mis});
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after that edge.
  task automatic step(input logic rst, input logic stall, input logic exc,
                      input logic redir, input logic [31:0] tgt,
                      input logic [31:0] exp_pc, input logic exp_v, input logic exp_m,
                      input string nm);
    exp_t e;
    i_rst         = rst;
    i_stall       = stall;
    i_exc         = exc;
    i_redirect    = redir;
    i_addr_target = tgt;
    @(posedge i_clk);
    #1;
    e.pc    = exp_pc;
    e.pcadd = exp_pc + 32'd4;
    e.vld   = exp_v;
    e.mis   = exp_m;
    e.nm    = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    //    rst  stl  exc  red  target         exp_pc         v     m
    step(1'b1,1'b0,1'b0,1'b0,32'h0,         32'h0,         1'b0, 1'b0, "reset");
    step(1'b1,1'b1,1'b1,1'b1,32'h0000_0777, 32'h0,         1'b0, 1'b0, "reset_ignores");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h4,         1'b1, 1'b0, "free1");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h8,         1'b1, 1'b0, "free2");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'hC,         1'b1, 1'b0, "free3");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h10,        1'b1, 1'b0, "free4");
    // Redirect without stall
    step(1'b0,1'b0,1'b0,1'b1,32'h200,       32'h200,       1'b1, 1'b0, "redir_200");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h204,       1'b1, 1'b0, "after_200");
    step(1'b0,1'b0,1'b0,1'b1,32'h20,        32'h20,        1'b1, 1'b0, "redir_20");
    // Redirects during stall: last one wins
    step(1'b0,1'b1,1'b0,1'b1,32'h300,       32'h20,        1'b1, 1'b0, "stall_red300");
    step(1'b0,1'b1,1'b0,1'b1,32'h400,       32'h20,        1'b1, 1'b0, "stall_red400");
    step(1'b0,1'b1,1'b0,1'b0,32'h0,         32'h20,        1'b1, 1'b0, "stall_hold");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h400,       1'b1, 1'b0, "release_400");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h404,       1'b1, 1'b0, "after_400");
    // Exception during stall discards pending
    step(1'b0,1'b1,1'b0,1'b1,32'h500,       32'h404,       1'b1, 1'b0, "stall_red500");
    step(1'b0,1'b1,1'b0,1'b0,32'h0,         32'h404,       1'b1, 1'b0, "stall_hold2");
    step(1'b0,1'b1,1'b1,1'b0,32'h0,         32'h180,       1'b1, 1'b0, "exc_in_stall");
    step(1'b0,1'b1,1'b0,1'b0,32'h0,         32'h180,       1'b1, 1'b0, "stall_after_exc");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h184,       1'b1, 1'b0, "pend_discarded");
    // New redirect on release beats the pending one and clears it
    step(1'b0,1'b1,1'b0,1'b1,32'h700,       32'h184,       1'b1, 1'b0, "stall_red700");
    step(1'b0,1'b0,1'b0,1'b1,32'h800,       32'h800,       1'b1, 1'b0, "release_red800");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h804,       1'b1, 1'b0, "pend_cleared");
    // Misaligned targets, applied and latched
    step(1'b0,1'b0,1'b0,1'b1,32'h1002,      32'h1000,      1'b1, 1'b1, "mis_applied");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h1004,      1'b1, 1'b0, "mis_one_cycle");
    step(1'b0,1'b1,1'b0,1'b1,32'h2003,      32'h1004,      1'b1, 1'b1, "mis_latched");
    step(1'b0,1'b1,1'b0,1'b0,32'h0,         32'h1004,      1'b1, 1'b0, "mis_latched_off");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h2000,      1'b1, 1'b0, "mis_pend_apply");
    // Exception beats simultaneous redirect; that target is not accepted
    step(1'b0,1'b0,1'b1,1'b1,32'h3001,      32'h180,       1'b1, 1'b0, "exc_over_redir");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h184,       1'b1, 1'b0, "after_exc");
    // Wrap-around
    step(1'b0,1'b0,1'b0,1'b1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, "redir_top");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h0,         1'b1, 1'b0, "wrap");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h4,         1'b1, 1'b0, "after_wrap");
    // Reset mid-stall with a pending redirect
    step(1'b0,1'b1,1'b0,1'b1,32'h900,       32'h4,         1'b1, 1'b0, "stall_red900");
    step(1'b1,1'b1,1'b0,1'b0,32'h0,         32'h0,         1'b0, 1'b0, "rst_mid_stall");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h4,         1'b1, 1'b0, "no_pend_after_rst");
    step(1'b0,1'b0,1'b0,1'b0,32'h0,         32'h8,         1'b1, 1'b0, "free_after_rst");

    i_redirect = 1'b0;
    i_stall    = 1'b0;
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge i_clk);
        budget--;
      end
      checks++;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_pc_gen.md
IF_PC_GEN -- requirements
Module: IF_pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports and of the PC register.
REQ-002 Parameter STEP, default 4, sequential increment in bytes; power of two, at least 1.
REQ-003 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded by reset.
REQ-004 Parameter EXC_VEC, default 32'h0000_0180, PC value loaded on exception.
REQ-005 Port i_clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port i_rst, input, 1, synchronous active-high reset.
REQ-007 Port i_stall, input, 1, hold the current PC (fetch stage blocked).
REQ-008 Port i_exc, input, 1, exception request; load EXC_VEC.
REQ-009 Port i_redirect, input, 1, branch/jump taken; load i_addr_target.
REQ-010 Port i_addr_target, input, ADDR_W, redirect target address.
REQ-011 Port o_addr_pc, output, ADDR_W, current fetch address (registered).
REQ-012 Port o_addr_pcadd4, output, ADDR_W, o_addr_pc + STEP (combinational, modulo 2^ADDR_W).
REQ-013 Port o_valid, output, 1, o_addr_pc holds a fetchable address this cycle.
REQ-014 Port o_misalign, output, 1, single-cycle flag: the last accepted target had nonzero bits below log2(STEP).

Function
REQ-015 Next-PC priority, highest first, SHALL be: i_rst, i_exc, i_redirect, pending redirect, i_stall, sequential.
REQ-016 i_exc SHALL load EXC_VEC next cycle regardless of i_stall, and SHALL clear any pending redirect.
REQ-017 i_redirect with i_stall low SHALL load i_addr_target (low log2(STEP) bits forced to 0) next cycle.
REQ-018 i_redirect with i_stall high SHALL NOT change the PC; the masked target SHALL be latched into a pending register with its pending flag set.
REQ-019 A later i_redirect during the same stall SHALL overwrite the pending target (last one wins).
REQ-020 On the first cycle with i_stall low and the pending flag set, the PC SHALL load the pending target and the flag SHALL clear; a simultaneous new i_redirect SHALL take precedence and also clear the flag.
REQ-021 With no higher-priority event and i_stall high, the PC SHALL hold its value.
REQ-022 Otherwise the PC SHALL advance by STEP, wrapping modulo 2^ADDR_W (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 o_misalign SHALL assert in the cycle after a redirect whose unmasked target is misaligned, whether applied or latched, for exactly one cycle.
REQ-024 o_valid SHALL be 0 in the first cycle after reset release and 1 thereafter; i_stall does not affect o_valid.
REQ-025 Latency: every PC change SHALL appear on o_addr_pc exactly one cycle after the event that causes it.

Reset
REQ-026 While i_rst is high: o_addr_pc = RESET_VEC, pending flag = 0, o_valid = 0, o_misalign = 0; all other inputs SHALL be ignored.
REQ-027 Reset asserted mid-stall with a pending redirect SHALL discard the pending redirect.

Structure
REQ-028 A shared package SHALL hold the defaults for ADDR_W, STEP, RESET_VEC and EXC_VEC.
REQ-029 The PC + STEP incrementer SHALL be instantiated as a sub-module, IF_pcadd_n, parametrised by ADDR_W and STEP.

Verification
REQ-030 Reset, then 3 free cycles -> o_addr_pc 0x0, 0x4, 0x8; o_valid 0 then 1.
REQ-031 PC=0x10, redirect to 0x200 with no stall -> next o_addr_pc 0x200, o_addr_pcadd4 0x204.
REQ-032 Stall at 0x20, redirect 0x300 then 0x400 during stall, release stall -> PC holds 0x20, then becomes 0x400, then 0x404.
REQ-033 Stall with pending 0x500, then i_exc -> PC 0x180 even though stalled; after stall release PC 0x184 (pending discarded).
REQ-034 Redirect to 0x1002 -> PC 0x1000, o_misalign high for exactly one cycle.
REQ-035 Force PC 0xFFFF_FFFC, one free cycle -> PC 0x0000_0000; i_rst asserted mid-stall with pending -> PC 0x0, no pending applied.
